imm_gen_queue: RTL

- Parametrised successor to the decode-stage immediate extender for the pipelined RISC-V core.
- Decodes I/S/B/U/J/shift-amount immediates for RV32 or RV64 (XLEN) under the one-hot EXTOp control.
- Flags illegal (zero or multi-hot) EXTOp encodings.
- Buffers results, each with a caller tag (PC or rd), in a DEPTH-entry FIFO between decode and execute, using valid/ready handshakes and a pipeline flush.

---
 rtl/imm_gen_queue.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/imm_gen_queue.sv
// Decode-stage immediate extender for RV32/RV64 with a small tagged FIFO
// between decode and execute (valid/ready on both sides, synchronous flush).

module imm_gen_queue #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned TAG_W   = 32,
  parameter int unsigned EXTOP_W = 6
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_inst,
  input  logic [EXTOP_W-1:0]           in_extop,
  input  logic [TAG_W-1:0]             in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XLEN-1:0]              out_imm,
  output logic [TAG_W-1:0]             out_tag,
  output logic                         out_illegal,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [5:0] OpShamt = 6'b100000;
  localparam logic [5:0] OpI     = 6'b010000;
  localparam logic [5:0] OpS     = 6'b001000;
  localparam logic [5:0] OpB     = 6'b000100;
  localparam logic [5:0] OpU     = 6'b000010;
  localparam logic [5:0] OpJ     = 6'b000001;

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_queue: XLEN must be 32 or 64");
  end
  if (EXTOP_W != 6) begin : g_bad_extop_w
    $error("imm_gen_queue: EXTOP_W must be 6");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $error("imm_gen_queue: DEPTH must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // Immediate decode
  // ---------------------------------------------------------------------------
  logic signed [31:0] simm;
  logic [5:0]         shamt;
  logic [XLEN-1:0]    dec_imm;
  logic               dec_illegal;
  logic               unused_opcode;

  assign unused_opcode = ^in_inst[6:0];
  assign shamt = (XLEN == 64) ? in_inst[25:20] : {1'b0, in_inst[24:20]};

  // All signed formats are built as 32-bit values, then sign-extended to XLEN.
  always_comb begin
    simm        = '0;
    dec_imm     = '0;
    dec_illegal = 1'b0;
    case (in_extop)
      OpShamt: dec_imm = XLEN'(shamt);
      OpI: begin
        simm    = 32'($signed(in_inst[31:20]));
        dec_imm = XLEN'(simm);
      end
      OpS: begin
        simm    = 32'($signed({in_inst[31:25], in_inst[11:7]}));
        dec_imm = XLEN'(simm);
      end
      OpB: begin
        simm    = 32'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
        dec_imm = XLEN'(simm);
      end
      OpU: begin
        simm    = $signed({in_inst[31:12], 12'b0});
        dec_imm = XLEN'(simm);
      end
      OpJ: begin
        simm    = 32'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
        dec_imm = XLEN'(simm);
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]  imm_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic             ill_mem [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;

  // No fall-through: a full FIFO refuses input even if the head pops this cycle.
  assign in_ready  = (count_q < CntW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  assign out_imm     = imm_mem[rd_ptr_q];
  assign out_tag     = tag_mem[rd_ptr_q];
  assign out_illegal = ill_mem[rd_ptr_q];
  assign count       = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        imm_mem[i] <= '0;
        tag_mem[i] <= '0;
        ill_mem[i] <= 1'b0;
      end
    end else if (push) begin
      imm_mem[wr_ptr_q] <= dec_imm;
      tag_mem[wr_ptr_q] <= in_tag;
      ill_mem[wr_ptr_q] <= dec_illegal;
    end
  end

endmodule
